dmx_frame_decoder: RTL
======================

Name: dmx_frame_decoder

Overview:
- Sits directly downstream of the DMX UART receiver inside top.
- Watches the raw rx line for the DMX break (at least 88 us low) and tracks the mark-after-break.
- Captures the start code, then numbers each following received byte as a slot (0-based) and writes it to the slot buffer through a simple write port.
- Reports frame completion and the slot count to the USB/host side.

Parameters:
- BREAK_MIN, 1408: consecutive low clocks on synchronised rx that qualify as a break (88 us at 16 MHz).
- MAX_SLOTS, 512: maximum data slots per frame; the frame ends when this count is reached.
- ADDR_W, 9: slot address width, equal to clog2(MAX_SLOTS).

Ports:
- clk, in, 1: system clock, 16 MHz.
- rstn, in, 1: synchronous reset, active-low.
- rx, in, 1: raw DMX line, asynchronous; synchronised internally.
- rx_data, in, 8: byte from the UART receiver.
- rx_rcv, in, 1: one-clock strobe marking rx_data valid.
- slot_we, out, 1: slot buffer write enable, one-clock pulse.
- slot_addr, out, ADDR_W: slot index; slot 1 maps to address 0.
- slot_data, out, 8: slot value.
- start_code, out, 8: start code of the current/last frame.
- frame_done, out, 1: one-clock pulse at end of frame.
- frame_slots, out, ADDR_W+1: slots in the completed frame; valid while frame_done is high and held afterwards.
- in_frame, out, 1: high in the START and SLOTS states.

Behaviour:
- Clock and reset: one clock, clk. Reset rstn is synchronous and active-low. All outputs are registered.
- Reset values: slot_we=0, slot_addr=0, slot_data=0, start_code=0, frame_done=0, frame_slots=0, in_frame=0, state=IDLE, break counter=0, sync flops=1.
- Reset mid-frame: abort immediately. No frame_done pulse and no further writes.
- rx synchroniser: two flops, giving rx_s. Break-detect latency of 2 clocks is acceptable.
- Break counter:
  - Increments while rx_s=0 and saturates at BREAK_MIN.
  - Clears on rx_s=1.
  - brk_det is a single-cycle pulse when the counter reaches BREAK_MIN-1 with rx_s=0.
- States:
  - IDLE: wait for brk_det, then go to BREAK. rx_rcv is ignored.
  - BREAK: rx_rcv is ignored; this drops the framing-error 0x00 the UART emits during a break. On rx_s=1, go to MAB.
  - MAB: the first rx_rcv latches start_code<=rx_data and goes to START, which sets in_frame=1. brk_det goes to BREAK.
  - START/SLOTS (one state after the start code; START names the first cycle):
    - Each rx_rcv issues a write: the next clock has slot_we=1, slot_addr=idx, slot_data=rx_data, then idx increments.
    - brk_det: frame_done=1, frame_slots=idx, idx=0, go to BREAK.
    - idx reaching MAX_SLOTS after a write: frame_done on the clock after that write (frame_slots=MAX_SLOTS), go to IDLE. Further bytes are ignored until the next break.
- Latency: rx_rcv to slot_we is exactly 1 clock.
- Write ordering: writes are in order, gapless, and never exceed MAX_SLOTS-1.
- Simultaneous rx_rcv and brk_det: the break wins and the byte is dropped.
- Low pulses shorter than BREAK_MIN (data bits, short glitches) never trigger a break.
- A break with zero slots after the start code gives frame_done with frame_slots=0.
- Breaks while in IDLE or BREAK never produce frame_done.
- Arithmetic:
  - idx is ADDR_W+1 bits; the count never wraps.
  - The break counter is clog2(BREAK_MIN+1) bits and saturates.

Decomposition:
- Package dmx_pkg holds:
  - the state enum {IDLE, BREAK, MAB, START, SLOTS}
  - DMX_MAX_SLOTS=512
  - DMX_BREAK_MIN_16MHZ=1408
  - the DMX_NULL_START=8'h00 constant
- One sub-module, dmx_break_detect: rx synchroniser plus saturating counter, outputs rx_s and brk_det.
- The decoder FSM and write port stay in the top of this block.

Test Plan:
- Normal frame:
  - Stimulus: BREAK_MIN=16; break of 360 us; start code 0x00; slots 0x01..0x0c; then a second break.
  - Response: 12 writes to addr 0..11 with data 0x01..0x0c, each 1 clock after rx_rcv. start_code=0x00. frame_done once at the second break with frame_slots=12.
- Break-byte filter:
  - Stimulus: UART strobes rx_rcv with 0x00 during the break.
  - Response: no slot_we; start_code is taken from the first byte after the MAB.
- Short low:
  - Stimulus: rx low for BREAK_MIN-1 clocks mid-frame, then bytes continue.
  - Response: no frame_done; writes continue at the next address.
- Full frame:
  - Stimulus: MAX_SLOTS=4; start code 0xCC then 6 bytes.
  - Response: writes to addr 0..3 only. frame_done with frame_slots=4 one clock after the 4th write. Bytes 5-6 are ignored. start_code=0xCC.
- Reset mid-frame:
  - Stimulus: rstn=0 for one clock after slot 3.
  - Response: next clock has all outputs zero and no frame_done. The next frame writes from addr 0.
- Break-only frame:
  - Stimulus: break, start code 0x17, break.
  - Response: frame_done with frame_slots=0 and start_code=0x17; no writes.

Source files
------------

// File: rtl/dmx_pkg.sv
// Shared DMX512 decoder types and constants.
// Pure definitions, no logic.
package dmx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    BREAK,
    MAB,
    START,
    SLOTS
  } dmx_state_t;

  localparam int          DMX_MAX_SLOTS       = 512;
  localparam int          DMX_BREAK_MIN_16MHZ = 1408;
  localparam logic [7:0]  DMX_NULL_START      = 8'h00;

endpackage

// File: rtl/dmx_break_detect.sv
// rx two-flop synchroniser plus saturating low-time counter; brk_det pulses once per break.
// Latency: rx_s lags rx by 2 clocks; no backpressure, free-running.
module dmx_break_detect
  import dmx_pkg::*;
#(
  parameter int BREAK_MIN = DMX_BREAK_MIN_16MHZ
) (
  input  logic clk,
  input  logic rstn,
  input  logic rx,
  output logic rx_s,
  output logic brk_det
);

  localparam int             CW      = $clog2(BREAK_MIN + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(BREAK_MIN);
  localparam logic [CW-1:0]  CNT_ARM = CW'(BREAK_MIN - 1);

  logic          rx_m;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      cnt  <= '0;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      if (rx_s) begin
        cnt <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Saturation past CNT_ARM guarantees a single pulse however long the break lasts.
  assign brk_det = !rx_s && (cnt == CNT_ARM);

endmodule

// File: rtl/dmx_frame_decoder.sv
// DMX512 framer: break/MAB tracking, start code capture, slot write port, frame completion report.
// Latency: rx_rcv to slot_we is 1 clock; no backpressure, bytes arriving outside a frame are dropped.
module dmx_frame_decoder
  import dmx_pkg::*;
#(
  parameter int BREAK_MIN = DMX_BREAK_MIN_16MHZ,
  parameter int MAX_SLOTS = DMX_MAX_SLOTS,
  parameter int ADDR_W    = $clog2(MAX_SLOTS)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              rx,
  input  logic [7:0]        rx_data,
  input  logic              rx_rcv,
  output logic              slot_we,
  output logic [ADDR_W-1:0] slot_addr,
  output logic [7:0]        slot_data,
  output logic [7:0]        start_code,
  output logic              frame_done,
  output logic [ADDR_W:0]   frame_slots,
  output logic              in_frame
);

  localparam int             IW      = ADDR_W + 1;
  localparam logic [IW-1:0]  IDX_MAX = IW'(MAX_SLOTS);

  logic rx_s;
  logic brk_det;

  dmx_break_detect #(
    .BREAK_MIN (BREAK_MIN)
  ) u_break_detect (
    .clk     (clk),
    .rstn    (rstn),
    .rx      (rx),
    .rx_s    (rx_s),
    .brk_det (brk_det)
  );

  dmx_state_t        state, state_nxt;
  logic [IW-1:0]     idx, idx_nxt;
  logic              we_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [7:0]        data_nxt;
  logic [7:0]        sc_nxt;
  logic              done_nxt;
  logic [IW-1:0]     fs_nxt;
  logic              in_frame_nxt;

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    we_nxt    = 1'b0;
    addr_nxt  = slot_addr;
    data_nxt  = slot_data;
    sc_nxt    = start_code;
    done_nxt  = 1'b0;
    fs_nxt    = frame_slots;
    case (state)
      IDLE: begin
        if (brk_det) state_nxt = BREAK;
      end
      BREAK: begin
        // The UART's framing-error byte during the break lands here and is dropped.
        if (rx_s) state_nxt = MAB;
      end
      MAB: begin
        if (brk_det) begin
          state_nxt = BREAK;
        end else if (rx_rcv) begin
          sc_nxt    = rx_data;
          idx_nxt   = '0;
          state_nxt = START;
        end
      end
      START, SLOTS: begin
        state_nxt = SLOTS;
        if (brk_det) begin
          done_nxt  = 1'b1;
          fs_nxt    = idx;
          idx_nxt   = '0;
          state_nxt = BREAK;
        end else if (idx == IDX_MAX) begin
          done_nxt  = 1'b1;
          fs_nxt    = idx;
          idx_nxt   = '0;
          state_nxt = IDLE;
        end else if (rx_rcv) begin
          we_nxt   = 1'b1;
          addr_nxt = idx[ADDR_W-1:0];
          data_nxt = rx_data;
          idx_nxt  = idx + IW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
    in_frame_nxt = (state_nxt == START) || (state_nxt == SLOTS);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= IDLE;
      idx         <= '0;
      slot_we     <= 1'b0;
      slot_addr   <= '0;
      slot_data   <= '0;
      start_code  <= DMX_NULL_START;
      frame_done  <= 1'b0;
      frame_slots <= '0;
      in_frame    <= 1'b0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      slot_we     <= we_nxt;
      slot_addr   <= addr_nxt;
      slot_data   <= data_nxt;
      start_code  <= sc_nxt;
      frame_done  <= done_nxt;
      frame_slots <= fs_nxt;
      in_frame    <= in_frame_nxt;
    end
  end

endmodule
